// File: rtl/cic_pkg.sv
// Shared CIC definitions: channel-tag width helper and two's-complement
// subtraction overflow detection used by the comb stages.
package cic_pkg;

    // Width of a channel tag; a single channel still carries a 1-bit tag.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Overflow of r = m - s: operands differ in sign and the result's sign
    // differs from the minuend's.
    function automatic logic sub_overflow(input logic m_msb,
                                          input logic s_msb,
                                          input logic r_msb);
        return (m_msb != s_msb) && (r_msb != m_msb);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One TDM comb stage: y = x - x(n-DIFF_DELAY) per channel, one register deep.
// Overflow tracking is built only when COMB_OVF_EN is defined.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIFF_DELAY = 1,
    parameter int NUM_CH     = 1,
    parameter int CH_W       = ch_width(NUM_CH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_x,
    input  logic             in_ovf,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_y,
    output logic             out_ovf
);

    logic [WIDTH-1:0] hist_q [NUM_CH][DIFF_DELAY];
    logic             valid_q;
    logic [CH_W-1:0]  ch_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] oldest;
    logic             accept;

    always_comb begin
        accept = in_valid && (int'(in_ch) < NUM_CH);
        oldest = '0;
        if (accept) begin
            oldest = hist_q[in_ch][DIFF_DELAY-1];
        end
        y_d = in_x - oldest;
    end

    // History is read above before this edge's shift, so same-channel
    // back-to-back samples need no forwarding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned d = 0; d < DIFF_DELAY; d++) begin
                    hist_q[c][d] <= '0;
                end
            end
            valid_q <= 1'b0;
            ch_q    <= '0;
            y_q     <= '0;
        end else if (clear) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                for (int unsigned d = 0; d < DIFF_DELAY; d++) begin
                    hist_q[c][d] <= '0;
                end
            end
            valid_q <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                hist_q[in_ch][0] <= in_x;
                for (int unsigned d = 1; d < DIFF_DELAY; d++) begin
                    hist_q[in_ch][d] <= hist_q[in_ch][d-1];
                end
                ch_q <= in_ch;
                y_q  <= y_d;
            end
        end
    end

`ifdef COMB_OVF_EN
    logic ovf_q;
    logic ovf_d;

    assign ovf_d = in_ovf | sub_overflow(in_x[WIDTH-1], oldest[WIDTH-1], y_d[WIDTH-1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (!clear && accept) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    // The chain feeds a constant 0 in, so the flag stays 0 with no storage.
    assign out_ovf = in_ovf;
`endif

    assign out_valid = valid_q;
    assign out_ch    = ch_q;
    assign out_y     = y_q;

endmodule

// File: rtl/cic_comb_chain.sv
// Cascaded multi-channel TDM CIC comb section, N_STAGES cycles of latency.
// Define COMB_OVF_EN to build per-sample signed-overflow detection.
module cic_comb_chain
    import cic_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  N_STAGES   = 3,
    parameter int  DIFF_DELAY = 1,
    parameter int  NUM_CH     = 1,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] y,
    output logic             overflow
);

    logic             st_valid [N_STAGES+1];
    logic [CH_W-1:0]  st_ch    [N_STAGES+1];
    logic [WIDTH-1:0] st_y     [N_STAGES+1];
    logic             st_ovf   [N_STAGES+1];

    assign st_valid[0] = in_valid;
    assign st_ch[0]    = in_ch;
    assign st_y[0]     = a;
    assign st_ovf[0]   = 1'b0;

    for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
        cic_comb_stage #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY),
            .NUM_CH     (NUM_CH),
            .CH_W       (CH_W)
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .clear     (clear),
            .in_valid  (st_valid[s]),
            .in_ch     (st_ch[s]),
            .in_x      (st_y[s]),
            .in_ovf    (st_ovf[s]),
            .out_valid (st_valid[s+1]),
            .out_ch    (st_ch[s+1]),
            .out_y     (st_y[s+1]),
            .out_ovf   (st_ovf[s+1])
        );
    end

    assign out_valid = st_valid[N_STAGES];
    assign out_ch    = st_ch[N_STAGES];
    assign y         = st_y[N_STAGES];
    assign overflow  = st_ovf[N_STAGES];

endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed self-checking bench for cic_comb_chain using three configurations
// sharing clock, reset and clear.
module tb_cic_comb_chain;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic exp_ovf;

    // u1: WIDTH=8, 1 stage, M=1, 1 channel
    logic       v1 = 1'b0;
    logic [0:0] ch1 = '0;
    logic [7:0] a1 = '0;
    logic       ov1;
    logic [0:0] och1;
    logic [7:0] y1;
    logic       of1;

    // u2: WIDTH=16, 2 stages, M=1, 1 channel
    logic        v2 = 1'b0;
    logic [0:0]  ch2 = '0;
    logic [15:0] a2 = '0;
    logic        ov2;
    logic [0:0]  och2;
    logic [15:0] y2;
    logic        of2;

    // u3: WIDTH=16, 1 stage, M=2, 3 channels
    logic        v3 = 1'b0;
    logic [1:0]  ch3 = '0;
    logic [15:0] a3 = '0;
    logic        ov3;
    logic [1:0]  och3;
    logic [15:0] y3;
    logic        of3;

    cic_comb_chain #(.WIDTH(8), .N_STAGES(1), .DIFF_DELAY(1), .NUM_CH(1)) u1 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(v1), .in_ch(ch1), .a(a1),
        .out_valid(ov1), .out_ch(och1), .y(y1), .overflow(of1)
    );

    cic_comb_chain #(.WIDTH(16), .N_STAGES(2), .DIFF_DELAY(1), .NUM_CH(1)) u2 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(v2), .in_ch(ch2), .a(a2),
        .out_valid(ov2), .out_ch(och2), .y(y2), .overflow(of2)
    );

    cic_comb_chain #(.WIDTH(16), .N_STAGES(1), .DIFF_DELAY(2), .NUM_CH(3)) u3 (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(v3), .in_ch(ch3), .a(a3),
        .out_valid(ov3), .out_ch(och3), .y(y3), .overflow(of3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v1 = 1'b0;
        v2 = 1'b0;
        v3 = 1'b0;
    endtask

    task automatic test_reset();
        #3 rstn = 1'b0;
        tick();
        tick();
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL reset_u1_valid: got %b want 0", ov1); end
        checks++; if (y1 !== 8'h00) begin failures++; $display("FAIL reset_u1_y: got %h want 00", y1); end
        checks++; if (och1 !== 1'b0) begin failures++; $display("FAIL reset_u1_ch: got %h want 0", och1); end
        checks++; if (of1 !== 1'b0) begin failures++; $display("FAIL reset_u1_ovf: got %b want 0", of1); end
        checks++; if (ov2 !== 1'b0 || y2 !== 16'h0) begin failures++; $display("FAIL reset_u2: got v=%b y=%h want v=0 y=0", ov2, y2); end
        checks++; if (ov3 !== 1'b0 || y3 !== 16'h0 || och3 !== 2'd0) begin failures++; $display("FAIL reset_u3: got v=%b y=%h ch=%0d want 0", ov3, y3, och3); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] ins [3];
        logic [7:0] exp [3];
        ins = '{8'd5, 8'd9, 8'd3};
        exp = '{8'd5, 8'd4, 8'hFA};
        for (int i = 0; i < 3; i++) begin
            v1 = 1'b1; a1 = ins[i];
            tick();
            checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d]: got %b want 1", i, ov1); end
            checks++; if (y1 !== exp[i]) begin failures++; $display("FAIL basic_y[%0d]: got %h want %h", i, y1, exp[i]); end
        end
        idle_all();
        tick();
        checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL basic_idle_valid: got %b want 0", ov1); end
        checks++; if (y1 !== 8'hFA) begin failures++; $display("FAIL basic_hold_y: got %h want fa", y1); end
    endtask

    task automatic test_overflow();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        v1 = 1'b1; a1 = 8'd127;
        tick();
        checks++; if (y1 !== 8'd127) begin failures++; $display("FAIL ovf_first_y: got %h want 7f", y1); end
        checks++; if (of1 !== 1'b0) begin failures++; $display("FAIL ovf_first_flag: got %b want 0", of1); end
        a1 = 8'h80;
        tick();
        checks++; if (y1 !== 8'd1) begin failures++; $display("FAIL ovf_wrap_y: got %h want 01", y1); end
        checks++; if (of1 !== exp_ovf) begin failures++; $display("FAIL ovf_flag: got %b want %b", of1, exp_ovf); end
        idle_all();
        tick();
        checks++; if (of1 !== exp_ovf) begin failures++; $display("FAIL ovf_hold: got %b want %b", of1, exp_ovf); end
    endtask

    task automatic test_impulse();
        logic [15:0] exp [5];
        exp = '{16'h0001, 16'hFFFE, 16'h0001, 16'h0000, 16'h0000};
        for (int k = 0; k < 8; k++) begin
            v2 = (k < 5);
            a2 = (k == 0) ? 16'd1 : 16'd0;
            tick();
            checks++; if (ov2 !== (k >= 1 && k <= 5)) begin failures++; $display("FAIL impulse_valid[%0d]: got %b want %b", k, ov2, (k >= 1 && k <= 5)); end
            if (k >= 1 && k <= 5) begin
                checks++; if (y2 !== exp[k-1]) begin failures++; $display("FAIL impulse_y[%0d]: got %h want %h", k, y2, exp[k-1]); end
            end
        end
        idle_all();
    endtask

    task automatic test_interleave();
        logic        tv [9];
        logic [1:0]  tc [9];
        logic [15:0] ta [9];
        logic [15:0] te [9];
        logic [15:0] last_y;
        logic [1:0]  last_ch;
        tv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tc = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
        ta = '{16'd10, 16'd0, 16'd1, 16'd20, 16'd0, 16'd0, 16'd2, 16'd30, 16'd3};
        te = '{16'd10, 16'd0, 16'd1, 16'd20, 16'd0, 16'd0, 16'd2, 16'd20, 16'd2};
        last_y = '0;
        last_ch = '0;
        for (int i = 0; i < 9; i++) begin
            v3 = tv[i]; ch3 = tc[i]; a3 = ta[i];
            tick();
            if (tv[i]) begin
                last_y = te[i];
                last_ch = tc[i];
            end
            checks++; if (ov3 !== tv[i]) begin failures++; $display("FAIL tdm_valid[%0d]: got %b want %b", i, ov3, tv[i]); end
            checks++; if (y3 !== last_y) begin failures++; $display("FAIL tdm_y[%0d]: got %0d want %0d", i, y3, last_y); end
            checks++; if (och3 !== last_ch) begin failures++; $display("FAIL tdm_ch[%0d]: got %0d want %0d", i, och3, last_ch); end
        end
        idle_all();
    endtask

    task automatic test_bad_channel();
        v3 = 1'b1; ch3 = 2'd3; a3 = 16'd50;
        tick();
        checks++; if (ov3 !== 1'b0) begin failures++; $display("FAIL badch_valid: got %b want 0", ov3); end
        checks++; if (y3 !== 16'd2) begin failures++; $display("FAIL badch_hold_y: got %0d want 2", y3); end
        ch3 = 2'd0; a3 = 16'd40;
        tick();
        checks++; if (ov3 !== 1'b1) begin failures++; $display("FAIL badch_next_valid: got %b want 1", ov3); end
        checks++; if (y3 !== 16'd20) begin failures++; $display("FAIL badch_next_y: got %0d want 20", y3); end
        checks++; if (och3 !== 2'd0) begin failures++; $display("FAIL badch_next_ch: got %0d want 0", och3); end
        idle_all();
        tick();
    endtask

    task automatic test_clear();
        v1 = 1'b1; a1 = 8'd50;
        v2 = 1'b1; a2 = 16'd5;
        tick();
        clear = 1'b1;
        a1 = 8'd99; a2 = 16'd99;
        tick();
        clear = 1'b0;
        checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin failures++; $display("FAIL clear_drop: got v1=%b v2=%b want 0 0", ov1, ov2); end
        idle_all();
        tick();
        checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin failures++; $display("FAIL clear_no_stale: got v1=%b v2=%b want 0 0", ov1, ov2); end
        v1 = 1'b1; a1 = 8'd7;
        v2 = 1'b1; a2 = 16'd7;
        tick();
        checks++; if (ov1 !== 1'b1 || y1 !== 8'd7) begin failures++; $display("FAIL clear_u1_first: got v=%b y=%0d want v=1 y=7", ov1, y1); end
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL clear_u2_latency: got %b want 0", ov2); end
        idle_all();
        tick();
        checks++; if (ov2 !== 1'b1 || y2 !== 16'd7) begin failures++; $display("FAIL clear_u2_first: got v=%b y=%0d want v=1 y=7", ov2, y2); end
        checks++; if (ov1 !== 1'b0 || y1 !== 8'd7) begin failures++; $display("FAIL clear_u1_hold: got v=%b y=%0d want v=0 y=7", ov1, y1); end
    endtask

    task automatic test_mid_reset();
        v1 = 1'b1; a1 = 8'd60;
        v2 = 1'b1; a2 = 16'd60;
        tick();
        idle_all();
        rstn = 1'b0;
        #1;
        checks++; if (ov1 !== 1'b0 || y1 !== 8'd0 || of1 !== 1'b0) begin failures++; $display("FAIL rst_async_u1: got v=%b y=%0d o=%b want 0", ov1, y1, of1); end
        checks++; if (ov2 !== 1'b0 || y2 !== 16'd0) begin failures++; $display("FAIL rst_async_u2: got v=%b y=%0d want 0", ov2, y2); end
        #2 rstn = 1'b1;
        tick();
        checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL rst_no_stale: got %b want 0", ov2); end
        v1 = 1'b1; a1 = 8'd7;
        v2 = 1'b1; a2 = 16'd7;
        tick();
        checks++; if (ov1 !== 1'b1 || y1 !== 8'd7) begin failures++; $display("FAIL rst_u1_first: got v=%b y=%0d want v=1 y=7", ov1, y1); end
        idle_all();
        tick();
        checks++; if (ov2 !== 1'b1 || y2 !== 16'd7) begin failures++; $display("FAIL rst_u2_first: got v=%b y=%0d want v=1 y=7", ov2, y2); end
    endtask

    initial begin
`ifdef COMB_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overflow();
        test_impulse();
        test_interleave();
        test_bad_channel();
        test_clear();
        test_mid_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
